// File: rtl/mult_pkg.sv
// Shared definitions for the 8x8 nibble-serial multiplier: controller state
// encoding, operand nibble selects and partial-product shift codes. Used by
// the controller, the shifter and the datapath top.
package mult_pkg;

   // Controller states. The encoding is visible on state_out for debug,
   // so the values are fixed rather than left to the synthesis tool.
   typedef enum logic [2:0] {
      ST_IDLE = 3'b000,
      ST_CLR  = 3'b001,
      ST_LSB  = 3'b010,
      ST_MID  = 3'b011,
      ST_MSB  = 3'b100,
      ST_DONE = 3'b101,
      ST_ERR  = 3'b110,
      ST_RSVD = 3'b111   // unreachable; decodes like IDLE and returns to it
   } state_t;

   // Partial-product shift codes driven on shift_sel (11 is never used).
   localparam logic [1:0] SH0 = 2'b00;
   localparam logic [1:0] SH4 = 2'b01;
   localparam logic [1:0] SH8 = 2'b10;

   // Operand nibble selects: bit1 picks the a nibble, bit0 the b nibble
   // (0 = low nibble, 1 = high nibble).
   localparam logic [1:0] SEL_ALO_BLO = 2'b00;
   localparam logic [1:0] SEL_ALO_BHI = 2'b01;
   localparam logic [1:0] SEL_AHI_BLO = 2'b10;
   localparam logic [1:0] SEL_AHI_BHI = 2'b11;

   // Everything the controller drives towards the datapath, grouped so the
   // output decoder can assign a complete default in one statement.
   typedef struct packed {
      logic [1:0] input_sel;
      logic [1:0] shift_sel;
      logic       clk_ena;
      logic       sclr_n;
      logic       done_flag;
      logic       err_flag;
   } ctrl_t;

   // Idle values of the control bundle: accumulator frozen, no clear,
   // no status flags, low nibbles selected, no shift.
   localparam ctrl_t CTRL_IDLE = '{
      input_sel : SEL_ALO_BLO,
      shift_sel : SH0,
      clk_ena   : 1'b0,
      sclr_n    : 1'b1,
      done_flag : 1'b0,
      err_flag  : 1'b0
   };

   // Shift distance in bits for a shift code; used by the shifter.
   // The unused code 11 maps to no shift.
   function automatic int unsigned shift_amount(input logic [1:0] sh);
      case (sh)
         SH4:     return 4;
         SH8:     return 8;
         default: return 0;
      endcase
   endfunction

   // True for the states in which the accumulator is being written.
   // A start request seen in any of these is a protocol violation.
   function automatic logic is_busy(input state_t st);
      return (st == ST_CLR) || (st == ST_LSB) ||
             (st == ST_MID) || (st == ST_MSB);
   endfunction

endpackage : mult_pkg

// File: rtl/mult_control.sv
// Control FSM for an 8x8 multiplier built from one 4x4 multiplier, a
// shifter and a 16-bit accumulator. One multiply takes five accumulator
// cycles: clear, then lo*lo <<0, lo*hi <<4, hi*lo <<4, hi*hi <<8.
// Moore machine: every output is decoded from the state and the MID counter.
module mult_control
   import mult_pkg::*;
(
   input  logic       clk,
   input  logic       aclr_n,
   input  logic       start,
   output logic [1:0] input_sel,
   output logic [1:0] shift_sel,
   output logic       clk_ena,
   output logic       sclr_n,
   output logic       done_flag,
   output logic       err_flag,
   output logic [2:0] state_out
);

   state_t state;
   state_t state_nxt;
   logic   cnt;        // which of the two middle partial products is next
   logic   cnt_nxt;
   ctrl_t  ctrl;

   // State and MID counter registers; reset forces IDLE at once, even mid-operation.
   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         state <= ST_IDLE;
         cnt   <= 1'b0;
      end else begin
         // NOTE: registered state uses non-blocking assignment so every flop
         // samples pre-edge values; blocking here would create order-dependent races.
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state and counter logic; a start while busy overrides the normal step.
   always_comb begin
      // NOTE: defaults first so every path assigns both variables; a missing
      // branch would otherwise infer a latch.
      state_nxt = state;
      cnt_nxt   = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_CLR;
         end

         ST_CLR: begin
            state_nxt = ST_LSB;
         end

         ST_LSB: begin
            // Entering MID always begins with the lo*hi product.
            state_nxt = ST_MID;
            cnt_nxt   = 1'b0;
         end

         ST_MID: begin
            if (!cnt) begin
               state_nxt = ST_MID;
               cnt_nxt   = 1'b1;
            end else begin
               state_nxt = ST_MSB;
               cnt_nxt   = 1'b0;
            end
         end

         ST_MSB: begin
            state_nxt = ST_DONE;
         end

         ST_DONE: begin
            // A new start restarts directly from DONE without visiting IDLE.
            if (start) state_nxt = ST_CLR;
         end

         ST_ERR: begin
            // Wait for the offending start to be released before recovering.
            if (!start) state_nxt = ST_IDLE;
         end

         default: begin
            // Unused encoding 111 behaves like IDLE for one cycle and leaves.
            state_nxt = ST_IDLE;
         end
      endcase

      // Start while the accumulator is being built corrupts the product;
      // flag it instead of silently restarting.
      if (is_busy(state) && start) begin
         state_nxt = ST_ERR;
         cnt_nxt   = 1'b0;
      end
   end

   // Output decode from registered state and counter only.
   always_comb begin
      ctrl = CTRL_IDLE;

      case (state)
         ST_IDLE: begin
            ctrl = CTRL_IDLE;
         end

         ST_CLR: begin
            // Synchronous clear of the accumulator on the next edge.
            ctrl.clk_ena = 1'b1;
            ctrl.sclr_n  = 1'b0;
         end

         ST_LSB: begin
            ctrl.clk_ena   = 1'b1;
            ctrl.input_sel = SEL_ALO_BLO;
            ctrl.shift_sel = SH0;
         end

         ST_MID: begin
            ctrl.clk_ena   = 1'b1;
            ctrl.shift_sel = SH4;
            ctrl.input_sel = cnt ? SEL_AHI_BLO : SEL_ALO_BHI;
         end

         ST_MSB: begin
            ctrl.clk_ena   = 1'b1;
            ctrl.input_sel = SEL_AHI_BHI;
            ctrl.shift_sel = SH8;
         end

         ST_DONE: begin
            ctrl.done_flag = 1'b1;
         end

         ST_ERR: begin
            ctrl.err_flag = 1'b1;
         end

         default: begin
            ctrl = CTRL_IDLE;
         end
      endcase
   end

   assign input_sel = ctrl.input_sel;
   assign shift_sel = ctrl.shift_sel;
   assign clk_ena   = ctrl.clk_ena;
   assign sclr_n    = ctrl.sclr_n;
   assign done_flag = ctrl.done_flag;
   assign err_flag  = ctrl.err_flag;
   assign state_out = state;

endmodule : mult_control

// File: tb/tb_mult_control.sv
// Testbench for mult_control. Surrounds the controller with a simple model of
// the nibble datapath (4x4 multiplier, shifter, 16-bit accumulator) so that the
// product it produces can be compared against a*b. Expected products are
// queued at each start; a monitor pops one per rising done_flag.
module tb_mult_control;

   logic       clk;
   logic       aclr_n;
   logic       start;
   logic [1:0] input_sel;
   logic [1:0] shift_sel;
   logic       clk_ena;
   logic       sclr_n;
   logic       done_flag;
   logic       err_flag;
   logic [2:0] state_out;

   logic [7:0]  a;
   logic [7:0]  b;
   logic [15:0] acc;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] exp_q[$];

   mult_control dut (
      .clk       (clk),
      .aclr_n    (aclr_n),
      .start     (start),
      .input_sel (input_sel),
      .shift_sel (shift_sel),
      .clk_ena   (clk_ena),
      .sclr_n    (sclr_n),
      .done_flag (done_flag),
      .err_flag  (err_flag),
      .state_out (state_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Datapath model driven by the controller's outputs.
   logic [3:0]  a_nib;
   logic [3:0]  b_nib;
   logic [15:0] pp;
   always_comb begin
      a_nib = input_sel[1] ? a[7:4] : a[3:0];
      b_nib = input_sel[0] ? b[7:4] : b[3:0];
      pp    = 16'(a_nib) * 16'(b_nib);
      if (shift_sel == 2'b01)      pp = pp << 4;
      else if (shift_sel == 2'b10) pp = pp << 8;
   end

   initial acc = 16'h0000;
   always @(posedge clk) begin
      if (clk_ena) begin
         if (!sclr_n) acc <= 16'h0000;
         else         acc <= acc + pp;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Observed outputs packed as {state_out, input_sel, shift_sel, clk_ena, sclr_n, done, err}.
   function automatic logic [10:0] obs();
      return {state_out, input_sel, shift_sel, clk_ena, sclr_n, done_flag, err_flag};
   endfunction

   localparam logic [10:0] MASK_ALL = 11'b111_11_11_1111;
   localparam logic [10:0] MASK_NOSEL = 11'b111_00_00_1111;
   localparam logic [10:0] O_IDLE = 11'b000_00_00_0100;
   localparam logic [10:0] O_ERR  = 11'b110_00_00_0101;

   // Expected outputs on the six edges following a start, from the state table.
   logic [10:0] exp_tr [6];
   logic [10:0] msk_tr [6];
   initial begin
      exp_tr[0] = 11'b001_00_00_1000; msk_tr[0] = MASK_NOSEL; // CLR
      exp_tr[1] = 11'b010_00_00_1100; msk_tr[1] = MASK_ALL;   // LSB
      exp_tr[2] = 11'b011_01_01_1100; msk_tr[2] = MASK_ALL;   // MID, cnt 0
      exp_tr[3] = 11'b011_10_01_1100; msk_tr[3] = MASK_ALL;   // MID, cnt 1
      exp_tr[4] = 11'b100_11_10_1100; msk_tr[4] = MASK_ALL;   // MSB
      exp_tr[5] = 11'b101_00_00_0110; msk_tr[5] = MASK_ALL;   // DONE
   end

   // Issue one multiply from IDLE or DONE and follow it edge by edge to DONE.
   task automatic run_mult(input logic [7:0] av, input logic [7:0] bv);
      a     = av;
      b     = bv;
      start = 1'b1;
      exp_q.push_back(16'(av) * 16'(bv));
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         check($sformatf("trace_step%0d", k), 32'(obs() & msk_tr[k]), 32'(exp_tr[k] & msk_tr[k]));
      end
   endtask

   // Scoreboard monitor: one expected product per rising done_flag.
   initial begin
      logic        prev_done;
      logic [15:0] e;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         check("done_err_exclusive", 32'(done_flag & err_flag), 32'd0);
         if (done_flag && !prev_done) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done: acc 0x%0h, no product expected", acc);
            end else begin
               e = exp_q.pop_front();
               check("product", 32'(acc), 32'(e));
            end
         end
         prev_done = done_flag;
      end
   end

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          clk_ena_seen;
      logic [15:0] acc_snap;

      aclr_n = 1'b0;
      start  = 1'b0;
      a      = 8'h00;
      b      = 8'h00;

      // Reset: IDLE values while aclr_n is low, even with the clock running.
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", 32'(obs()), 32'(O_IDLE));

      // Release with start already high: the first edge after release honours it.
      // Scenario 1: 0xFF * 0xFF = 0xFE01, done six edges after start.
      aclr_n = 1'b1;
      run_mult(8'hFF, 8'hFF);

      // Scenario 2 and 3: restarts straight from DONE.
      run_mult(8'h12, 8'h34);
      run_mult(8'h0A, 8'h0B);

      // Scenario 4: start in MID -> ERR, then IDLE once start is low.
      a     = 8'h5A;
      b     = 8'hC3;
      start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         check($sformatf("err_trace_step%0d", k), 32'(obs() & msk_tr[k]), 32'(exp_tr[k] & msk_tr[k]));
      end
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("err_state", 32'(obs() & MASK_NOSEL), 32'(O_ERR & MASK_NOSEL));
      @(posedge clk);
      #1;
      check("err_recover_idle", 32'(obs()), 32'(O_IDLE));

      // Scenario 6: 20 idle cycles leave the accumulator untouched.
      acc_snap     = acc;
      clk_ena_seen = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (clk_ena) clk_ena_seen++;
      end
      check("idle_clk_ena_count", 32'(clk_ena_seen), 32'd0);
      check("idle_acc_hold", 32'(acc), 32'(acc_snap));
      check("idle_state", 32'(obs()), 32'(O_IDLE));

      // Scenario 5: asynchronous reset in MSB, between clock edges.
      a     = 8'h77;
      b     = 8'h99;
      start = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      check("pre_reset_msb", 32'(obs()), 32'(exp_tr[4]));
      #2;
      aclr_n = 1'b0;
      #1;
      check("async_reset_outputs", 32'(obs()), 32'(O_IDLE));
      #1;
      aclr_n = 1'b1;
      clk_ena_seen = 0;
      repeat (5) begin
         @(posedge clk);
         #1;
         if (obs() != O_IDLE) clk_ena_seen++;
      end
      check("post_reset_quiet_cycles", 32'(clk_ena_seen), 32'd0);

      // Randomized multiplies with random dwell in DONE between restarts.
      for (int i = 0; i < 25; i++) begin
         run_mult(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
      end
      run_mult(8'h00, 8'hFF);
      run_mult(8'hFF, 8'h01);

      // Let the monitor consume the last product.
      for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(posedge clk);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_mult_control
